// File: rtl/cups_pkg.sv
// Shared constants for the write-back / register-file slice:
// write codes, the fixed R15 address and the RUN/EXC state encoding.
package cups_pkg;

    localparam logic [2:0] WB_NONE   = 3'b000;
    localparam logic [2:0] WB_ALU    = 3'b001;
    localparam logic [2:0] WB_LOAD   = 3'b010;
    localparam logic [2:0] WB_MULDIV = 3'b011;
    localparam logic [2:0] WB_SWAP   = 3'b100;

    localparam logic [3:0] R15_ADDR = 4'hF;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } wbState_e;

    // Codes 001..100 are the ones that write and can raise overflow; 101..111 are reserved.
    function automatic logic isWriteCode(input logic [2:0] code);
        logic res;
        case (code)
            WB_ALU, WB_LOAD, WB_MULDIV, WB_SWAP: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB bundle, decode-stage read ports and exception handshake of wb_regfile.
interface wb_regfile_if #(
    parameter int W = 16
);
    logic [W-1:0] wbALUout;
    logic [W-1:0] wbRD;
    logic [W-1:0] wbRD1;
    logic [W-1:0] wbRD15;
    logic [3:0]   wbOP1;
    logic [3:0]   wbOP2;
    logic [2:0]   wbregWrite;
    logic         wbF;
    logic         of;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;
    logic [W-1:0] r15data;
    logic         exc;
    logic [3:0]   exc_reg;
    logic         exc_ack;

    modport master (
        output wbALUout, wbRD, wbRD1, wbRD15, wbOP1, wbOP2, wbregWrite, wbF, of,
        output ra1, ra2, exc_ack,
        input  rdata1, rdata2, r15data, exc, exc_reg
    );

    modport slave (
        input  wbALUout, wbRD, wbRD1, wbRD15, wbOP1, wbOP2, wbregWrite, wbF, of,
        input  ra1, ra2, exc_ack,
        output rdata1, rdata2, r15data, exc, exc_reg
    );

endinterface

// File: rtl/wb_regfile_regfile16.sv
// 16 x W register array with two prioritised write ports (A beats B on the
// same address) and three raw asynchronous read ports.
module regfile16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         weA,
    input  logic [3:0]   waA,
    input  logic [W-1:0] wdA,
    input  logic         weB,
    input  logic [3:0]   waB,
    input  logic [W-1:0] wdB,
    input  logic [3:0]   raddr0,
    input  logic [3:0]   raddr1,
    input  logic [3:0]   raddr2,
    output logic [W-1:0] rdata0,
    output logic [W-1:0] rdata1,
    output logic [W-1:0] rdata2
);

    logic [W-1:0] mem_r [16];

    // Array update: port A has priority over port B when both hit one register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (weA && (waA == 4'(i))) begin
                    mem_r[i] <= wdA;
                end else if (weB && (waB == 4'(i))) begin
                    mem_r[i] <= wdB;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the MEM/WB bundle into two prioritised write ports,
// tracks the sticky overflow exception and bypasses committing writes to reads.
module wb_regfile
    import cups_pkg::*;
#(
    parameter int W      = 16,
    parameter bit EXC_EN = 1'b1
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);

    wbState_e     state_r;
    wbState_e     stateNext_s;
    logic         exc_r;
    logic         excNext_s;
    logic [3:0]   excReg_r;
    logic [3:0]   excRegNext_s;

    logic         ovfTrig_s;
    logic         commit_s;
    logic         weA_s;
    logic [3:0]   waA_s;
    logic [W-1:0] wdA_s;
    logic         weB_s;
    logic [3:0]   waB_s;
    logic [W-1:0] wdB_s;

    logic [W-1:0] raw1_s;
    logic [W-1:0] raw2_s;
    logic [W-1:0] raw15_s;

    // Decide whether this WB instruction commits, overflows, or is ignored.
    always_comb begin
        ovfTrig_s = 1'b0;
        commit_s  = 1'b0;
        if ((state_r == ST_RUN) && !bus.wbF && isWriteCode(bus.wbregWrite)) begin
            if (EXC_EN && bus.of) begin
                ovfTrig_s = 1'b1;
            end else begin
                commit_s = 1'b1;
            end
        end else begin
            ovfTrig_s = 1'b0;
            commit_s  = 1'b0;
        end
    end

    // Map write codes onto ports; R15 side result and the swap primary go on port A.
    always_comb begin
        weA_s = 1'b0;
        waA_s = bus.wbOP1;
        wdA_s = bus.wbALUout;
        weB_s = 1'b0;
        waB_s = bus.wbOP2;
        wdB_s = bus.wbRD1;
        case (bus.wbregWrite)
            WB_ALU: begin
                weA_s = commit_s;
            end
            WB_LOAD: begin
                weA_s = commit_s;
                wdA_s = bus.wbRD;
            end
            WB_MULDIV: begin
                weA_s = commit_s;
                waA_s = R15_ADDR;
                wdA_s = bus.wbRD15;
                weB_s = commit_s;
                waB_s = bus.wbOP1;
                wdB_s = bus.wbALUout;
            end
            WB_SWAP: begin
                weA_s = commit_s;
                weB_s = commit_s;
            end
            default: begin
                weA_s = 1'b0;
                weB_s = 1'b0;
            end
        endcase
    end

    regfile16 #(.W(W)) uArray (
        .clk    (clk),
        .reset  (reset),
        .weA    (weA_s),
        .waA    (waA_s),
        .wdA    (wdA_s),
        .weB    (weB_s),
        .waB    (waB_s),
        .wdB    (wdB_s),
        .raddr0 (bus.ra1),
        .raddr1 (bus.ra2),
        .raddr2 (R15_ADDR),
        .rdata0 (raw1_s),
        .rdata1 (raw2_s),
        .rdata2 (raw15_s)
    );

    function automatic logic [W-1:0] bypass(input logic [3:0] addr, input logic [W-1:0] raw);
        logic [W-1:0] res;
        if (weA_s && (waA_s == addr)) begin
            res = wdA_s;
        end else if (weB_s && (waB_s == addr)) begin
            res = wdB_s;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Same-cycle forwarding with the array's own write priority.
    always_comb begin
        bus.rdata1  = raw1_s;
        bus.rdata2  = raw2_s;
        bus.r15data = raw15_s;
        bus.rdata1  = bypass(bus.ra1, raw1_s);
        bus.rdata2  = bypass(bus.ra2, raw2_s);
        bus.r15data = bypass(R15_ADDR, raw15_s);
    end

    // State and exception registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_RUN;
            exc_r    <= 1'b0;
            excReg_r <= 4'h0;
        end else begin
            state_r  <= stateNext_s;
            exc_r    <= excNext_s;
            excReg_r <= excRegNext_s;
        end
    end

    // RUN/EXC transitions; an ack in EXC wins over any overflow that cycle.
    always_comb begin
        stateNext_s  = state_r;
        excNext_s    = exc_r;
        excRegNext_s = excReg_r;
        case (state_r)
            ST_RUN: begin
                if (ovfTrig_s) begin
                    stateNext_s  = ST_EXC;
                    excNext_s    = 1'b1;
                    excRegNext_s = bus.wbOP1;
                end else begin
                    stateNext_s = ST_RUN;
                end
            end
            ST_EXC: begin
                if (bus.exc_ack) begin
                    stateNext_s = ST_RUN;
                    excNext_s   = 1'b0;
                end else begin
                    stateNext_s = ST_EXC;
                end
            end
            default: begin
                stateNext_s = ST_RUN;
                excNext_s   = 1'b0;
            end
        endcase
    end

    assign bus.exc     = exc_r;
    assign bus.exc_reg = excReg_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, a reset-in-EXC
// sequence, then randomized traffic against an array-level reference model.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.W(16)) bus ();

    wb_regfile #(.W(16), .EXC_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  code;
        logic [3:0]  op1;
        logic [3:0]  op2;
        logic [15:0] alu;
        logic [15:0] rd;
        logic [15:0] rd1;
        logic [15:0] rd15;
        logic        f;
        logic        ovf;
        logic        ack;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e15;
        logic        eExc;
        logic [3:0]  eReg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] code, input logic [3:0] op1, input logic [3:0] op2,
                                input logic [15:0] alu, input logic [15:0] rd, input logic [15:0] rd1,
                                input logic [15:0] rd15, input logic f, input logic ovf, input logic ack,
                                input logic [3:0] ra1, input logic [3:0] ra2, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e15, input logic eExc,
                                input logic [3:0] eReg);
        vec_t v;
        v.code = code; v.op1 = op1; v.op2 = op2; v.alu = alu; v.rd = rd; v.rd1 = rd1;
        v.rd15 = rd15; v.f = f; v.ovf = ovf; v.ack = ack; v.ra1 = ra1; v.ra2 = ra2;
        v.e1 = e1; v.e2 = e2; v.e15 = e15; v.eExc = eExc; v.eReg = eReg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wbregWrite = v.code; bus.wbOP1 = v.op1; bus.wbOP2 = v.op2;
        bus.wbALUout = v.alu; bus.wbRD = v.rd; bus.wbRD1 = v.rd1; bus.wbRD15 = v.rd15;
        bus.wbF = v.f; bus.of = v.ovf; bus.exc_ack = v.ack; bus.ra1 = v.ra1; bus.ra2 = v.ra2;
    endtask

    // Reference model state
    logic [15:0] mdl[16];
    logic [15:0] nxt[16];
    logic        mExc;
    logic [3:0]  mReg;

    vec_t v;
    vec_t idle;

    initial begin
        idle = mk(3'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd15,
                  16'h0, 16'h0, 16'h0, 1'b0, 4'd0);
        drive(idle);

        //        code op1 op2 alu      rd       rd1      rd15     f  of ack ra1 ra2 e1       e2       e15      exc reg
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 4'd15, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0));
        vecs.push_back(mk(3'd1, 4'd2, 4'd0, 16'hA0A0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0,  16'hA0A0, 16'h0000, 16'h0000, 1'b0, 4'd0));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2,  16'hA0A0, 16'hA0A0, 16'h0000, 1'b0, 4'd0));
        vecs.push_back(mk(3'd3, 4'd15,4'd0, 16'h1BEA, 16'h0000, 16'h0000, 16'h0098, 1'b0, 1'b0, 1'b0, 4'd15,4'd2,  16'h0098, 16'hA0A0, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd3, 4'd4, 4'd0, 16'h1BEA, 16'h0000, 16'h0000, 16'h0098, 1'b0, 1'b0, 1'b0, 4'd4, 4'd15, 16'h1BEA, 16'h0098, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd4, 4'd15, 16'h1BEA, 16'h0098, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd1, 4'd1, 4'd0, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd4,  16'h0A0A, 16'h1BEA, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd1, 4'd5, 4'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 4'd1,  16'h1234, 16'h0A0A, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd4, 4'd1, 4'd5, 16'h1234, 16'h0000, 16'h0A0A, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd5,  16'h1234, 16'h0A0A, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd5,  16'h1234, 16'h0A0A, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd4, 4'd7, 4'd7, 16'h7777, 16'h0000, 16'h8888, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7,  16'h7777, 16'h7777, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd7, 4'd1,  16'h7777, 16'h1234, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd1, 4'd6, 4'd0, 16'h1BEA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd6, 4'd6,  16'h0000, 16'h0000, 16'h0098, 1'b0, 4'd0));
        vecs.push_back(mk(3'd1, 4'd6, 4'd0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd6, 4'd2,  16'h0000, 16'hA0A0, 16'h0098, 1'b1, 4'd6));
        vecs.push_back(mk(3'd1, 4'd6, 4'd0, 16'h6666, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd6, 4'd6,  16'h0000, 16'h0000, 16'h0098, 1'b1, 4'd6));
        vecs.push_back(mk(3'd1, 4'd6, 4'd0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd6, 4'd6,  16'h5555, 16'h5555, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd6, 4'd5,  16'h5555, 16'h0A0A, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd1, 4'd8, 4'd0, 16'hDEAD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd8, 4'd8,  16'h0000, 16'h0000, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd6, 4'd8, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8,  16'h0000, 16'h0000, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd8, 4'd6,  16'h0000, 16'h5555, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd8, 4'd9,  16'h0000, 16'h0000, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd2, 4'd9, 4'd0, 16'h1111, 16'hC0DE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9,  16'hC0DE, 16'hC0DE, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd0, 4'd3, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd9, 4'd1,  16'hC0DE, 16'h1234, 16'h0098, 1'b0, 4'd6));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd9,  16'h1234, 16'hC0DE, 16'h0098, 1'b0, 4'd6));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed table: each row is one WB cycle, outputs checked mid-cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #4;
            chk($sformatf("row%0d_rdata1", i), bus.rdata1, vecs[i].e1);
            chk($sformatf("row%0d_rdata2", i), bus.rdata2, vecs[i].e2);
            chk($sformatf("row%0d_r15data", i), bus.r15data, vecs[i].e15);
            chk($sformatf("row%0d_exc", i), {15'h0, bus.exc}, {15'h0, vecs[i].eExc});
            chk($sformatf("row%0d_exc_reg", i), {12'h0, bus.exc_reg}, {12'h0, vecs[i].eReg});
            @(posedge clk);
            #1;
        end

        // Reset arriving while an exception is pending.
        v = idle;
        v.code = 3'd1; v.op1 = 4'd10; v.alu = 16'h1111; v.ovf = 1'b1;
        drive(v);
        @(posedge clk);
        #1 drive(idle);
        #2;
        chk("pre_reset_exc", {15'h0, bus.exc}, 16'h0001);
        chk("pre_reset_exc_reg", {12'h0, bus.exc_reg}, 16'h000A);
        chk("pre_reset_rdata2", bus.rdata2, 16'h0098);
        reset = 1'b1;
        #1;
        chk("reset_exc", {15'h0, bus.exc}, 16'h0000);
        chk("reset_exc_reg", {12'h0, bus.exc_reg}, 16'h0000);
        chk("reset_rdata1", bus.rdata1, 16'h0000);
        chk("reset_r15data", bus.r15data, 16'h0000);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_exc", {15'h0, bus.exc}, 16'h0000);

        // Randomized traffic against the array-level model.
        for (int r = 0; r < 16; r++) mdl[r] = 16'h0000;
        mExc = 1'b0;
        mReg = 4'd0;
        for (int n = 0; n < 800; n++) begin
            logic active;
            logic ovfHit;
            v = idle;
            v.code = 3'($urandom_range(0, 7));
            v.op1  = 4'($urandom_range(0, 15));
            v.op2  = ($urandom_range(0, 3) == 0) ? v.op1 : 4'($urandom_range(0, 15));
            v.alu  = 16'($urandom);
            v.rd   = 16'($urandom);
            v.rd1  = 16'($urandom);
            v.rd15 = 16'($urandom);
            v.f    = ($urandom_range(0, 7) == 0);
            v.ovf  = ($urandom_range(0, 9) == 0);
            v.ack  = ($urandom_range(0, 3) == 0);
            v.ra1  = ($urandom_range(0, 1) == 0) ? v.op1 : 4'($urandom_range(0, 15));
            v.ra2  = ($urandom_range(0, 1) == 0) ? v.op2 : 4'($urandom_range(0, 15));

            active = !mExc && !v.f && (v.code >= 3'd1) && (v.code <= 3'd4);
            ovfHit = active && v.ovf;
            nxt = mdl;
            if (active && !ovfHit) begin
                case (v.code)
                    3'd1: nxt[v.op1] = v.alu;
                    3'd2: nxt[v.op1] = v.rd;
                    3'd3: begin nxt[v.op1] = v.alu; nxt[15] = v.rd15; end
                    3'd4: begin nxt[v.op2] = v.rd1; nxt[v.op1] = v.alu; end
                    default: ;
                endcase
            end

            drive(v);
            #4;
            chk("rnd_rdata1", bus.rdata1, nxt[v.ra1]);
            chk("rnd_rdata2", bus.rdata2, nxt[v.ra2]);
            chk("rnd_r15data", bus.r15data, nxt[15]);
            chk("rnd_exc", {15'h0, bus.exc}, {15'h0, mExc});
            chk("rnd_exc_reg", {12'h0, bus.exc_reg}, {12'h0, mReg});
            @(posedge clk);
            #1;
            mdl = nxt;
            if (ovfHit) begin
                mExc = 1'b1;
                mReg = v.op1;
            end else if (mExc && v.ack) begin
                mExc = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
